// File: rtl/dmem_arbiter.sv
// Weighted round-robin arbiter sharing one synchronous-read data-memory port
// between requesters A and B. Optional lock support: define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int unsigned WEIGHT_A = 1,
    parameter int unsigned WEIGHT_B = 1
) (
    input  logic        clk,
    input  logic        reset,
`ifdef DMEM_ARB_LOCK_EN
    input  logic        a_lock,
    input  logic        b_lock,
`endif
    input  logic        a_req,
    input  logic [31:0] a_addr,
    input  logic [3:0]  a_wmask,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic [31:0] b_addr,
    input  logic [3:0]  b_wmask,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_data
);

    localparam logic [4:0] WA = (WEIGHT_A == 0) ? 5'd1 : 5'(WEIGHT_A);
    localparam logic [4:0] WB = (WEIGHT_B == 0) ? 5'd1 : 5'(WEIGHT_B);

    logic       prio;
    logic [3:0] cnt;
    logic       owner_q;
    logic       vld_q;
    logic       eff_prio;
    logic       contended;
    logic       any_gnt;
    logic [4:0] cnt_inc;
    logic [4:0] w_sel;

`ifdef DMEM_ARB_LOCK_EN
    logic lock_q;
    logic lock_own;
    logic lock_hold;

    assign lock_hold = lock_q && (lock_own ? b_lock : a_lock);
    // A lock released this cycle hands priority straight to the other side
    assign eff_prio  = (lock_q && !lock_hold) ? ~lock_own : prio;
`else
    assign eff_prio  = prio;
`endif

    assign contended = a_req && b_req;
    assign any_gnt   = a_gnt || b_gnt;
    assign cnt_inc   = {1'b0, cnt} + 5'd1;
    assign w_sel     = b_gnt ? WB : WA;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset) begin
`ifdef DMEM_ARB_LOCK_EN
            if (lock_hold) begin
                a_gnt = a_req && !lock_own;
                b_gnt = b_req && lock_own;
            end else
`endif
            begin
                if (contended) begin
                    a_gnt = !eff_prio;
                    b_gnt = eff_prio;
                end else begin
                    a_gnt = a_req;
                    b_gnt = b_req;
                end
            end
        end
    end

    // Idle port issues a harmless read at A's address
    assign mem_addr  = b_gnt ? b_addr : a_addr;
    assign mem_wdata = b_gnt ? b_wdata : a_wdata;
    assign mem_wmask = a_gnt ? a_wmask : (b_gnt ? b_wmask : 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio    <= 1'b0;
            cnt     <= 4'd0;
            owner_q <= 1'b0;
            vld_q   <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            lock_q   <= 1'b0;
            lock_own <= 1'b0;
`endif
        end else begin
            vld_q <= any_gnt;
            if (any_gnt) begin
                owner_q <= b_gnt;
            end
`ifdef DMEM_ARB_LOCK_EN
            if (!lock_hold) begin
                if (a_gnt && a_lock) begin
                    lock_q   <= 1'b1;
                    lock_own <= 1'b0;
                end else if (b_gnt && b_lock) begin
                    lock_q   <= 1'b1;
                    lock_own <= 1'b1;
                end else begin
                    lock_q   <= 1'b0;
                end
            end
            if (any_gnt && !lock_hold) begin
`else
            if (any_gnt) begin
`endif
                if (contended && cnt_inc != w_sel) begin
                    cnt  <= cnt_inc[3:0];
                    prio <= b_gnt;
                end else begin
                    cnt  <= 4'd0;
                    prio <= a_gnt;
                end
            end
        end
    end

    assign a_rvalid = vld_q && !owner_q;
    assign b_rvalid = vld_q && owner_q;
    assign a_rdata  = mem_data;
    assign b_rdata  = mem_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a behavioural
// model of arbitration order and memory contents.
module tb_dmem_arbiter;

    localparam int WA = 2;
    localparam int WB = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0;
    logic [31:0] a_addr = '0;
    logic [3:0]  a_wmask = '0;
    logic [31:0] a_wdata = '0;
    logic        a_gnt, a_rvalid;
    logic [31:0] a_rdata;
    logic        b_req = 1'b0;
    logic [31:0] b_addr = '0;
    logic [3:0]  b_wmask = '0;
    logic [31:0] b_wdata = '0;
    logic        b_gnt, b_rvalid;
    logic [31:0] b_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_data = '0;
`ifdef DMEM_ARB_LOCK_EN
    logic        a_lock = 1'b0;
    logic        b_lock = 1'b0;
`endif

    dmem_arbiter #(.WEIGHT_A(WA), .WEIGHT_B(WB)) dut (
        .clk(clk), .reset(reset),
`ifdef DMEM_ARB_LOCK_EN
        .a_lock(a_lock), .b_lock(b_lock),
`endif
        .a_req(a_req), .a_addr(a_addr), .a_wmask(a_wmask), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_addr(b_addr), .b_wmask(b_wmask), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // Memory behind the arbiter, with a backdoor for preloading words
    logic [31:0] ram [0:16383];
    logic        bd_en = 1'b0;
    logic [13:0] bd_idx = '0;
    logic [31:0] bd_val = '0;

    always @(posedge clk) begin
        mem_data <= ram[mem_addr[15:2]];
        for (int i = 0; i < 4; i++)
            if (mem_wmask[i])
                ram[mem_addr[15:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        if (bd_en) ram[bd_idx] <= bd_val;
    end

    // Reference model
    logic [31:0] mmem [0:16383];
    int          turn, streak;
    logic        exp_vld;
    logic        exp_own;
    logic [31:0] exp_data;

    logic        pa, pb;
    logic [31:0] pa_addr, pa_wdata, pb_addr, pb_wdata;
    logic [3:0]  pa_mask, pb_mask;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        bd_en = 1'b1; bd_idx = 14'(idx); bd_val = val;
        mmem[idx] = val;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    task automatic model_reset();
        turn = 0; streak = 0; exp_vld = 1'b0; exp_own = 1'b0;
        pa = 1'b0; pb = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        a_req = 1'b1; b_req = 1'b1;
        a_wmask = 4'hF; b_wmask = 4'hF;
        @(posedge clk);
        #1;
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_wmask", mem_wmask, 0);
        check("rst_rvalid", {a_rvalid, b_rvalid}, 0);
        @(negedge clk);
        reset = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        a_wmask = 4'h0; b_wmask = 4'h0;
        model_reset();
    endtask

    task automatic run_cycle(output int w);
        logic [31:0] addr, wd, word;
        logic [3:0]  mk;
        @(negedge clk);
        a_req = pa; a_addr = pa_addr; a_wmask = pa_mask; a_wdata = pa_wdata;
        b_req = pb; b_addr = pb_addr; b_wmask = pb_mask; b_wdata = pb_wdata;
        #1;
        if (pa && pb) w = turn;
        else if (pa) w = 0;
        else if (pb) w = 1;
        else w = 2;
        check("a_gnt", a_gnt, w == 0);
        check("b_gnt", b_gnt, w == 1);
        addr = (w == 1) ? pb_addr : pa_addr;
        mk   = (w == 0) ? pa_mask : ((w == 1) ? pb_mask : 4'd0);
        wd   = (w == 1) ? pb_wdata : pa_wdata;
        check("mem_addr", mem_addr, addr);
        check("mem_wmask", mem_wmask, mk);
        if (w != 2) check("mem_wdata", mem_wdata, wd);
        check("a_rvalid", a_rvalid, exp_vld && !exp_own);
        check("b_rvalid", b_rvalid, exp_vld && exp_own);
        if (exp_vld) check("rdata", exp_own ? b_rdata : a_rdata, exp_data);
        exp_vld = (w != 2);
        if (w != 2) begin
            word = mmem[addr[15:2]];
            exp_own  = (w == 1);
            exp_data = word;
            for (int i = 0; i < 4; i++)
                if (mk[i]) word[8*i +: 8] = wd[8*i +: 8];
            mmem[addr[15:2]] = word;
            if (pa && pb) begin
                streak++;
                if (streak == ((w == 0) ? WA : WB)) begin
                    turn = 1 - w; streak = 0;
                end else begin
                    turn = w;
                end
            end else begin
                turn = 1 - w; streak = 0;
            end
            if (w == 0) pa = 1'b0; else pb = 1'b0;
        end
    endtask

    task automatic new_a(input logic [31:0] ad, input logic [3:0] m,
                         input logic [31:0] d);
        pa = 1'b1; pa_addr = ad; pa_mask = m; pa_wdata = d;
    endtask

    task automatic new_b(input logic [31:0] ad, input logic [3:0] m,
                         input logic [31:0] d);
        pb = 1'b1; pb_addr = ad; pb_mask = m; pb_wdata = d;
    endtask

    function automatic logic [31:0] rnd_addr();
        return $urandom & 32'hFFFF_003F;
    endfunction

    function automatic logic [3:0] rnd_mask();
        logic [3:0] m;
        m = 4'($urandom);
        return ($urandom_range(0, 1) == 0) ? 4'd0 : m;
    endfunction

    int w;
    int exp2 [6] = '{0, 0, 1, 0, 0, 1};

    initial begin
        pa = 1'b0; pb = 1'b0;
        pa_addr = '0; pa_mask = '0; pa_wdata = '0;
        pb_addr = '0; pb_mask = '0; pb_wdata = '0;
        model_reset();
        do_reset();
        for (int i = 0; i < 16; i++) set_word(i, $urandom);

        // Weighted sequence with both requesting continuously
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (!pa) new_a(rnd_addr(), 4'd0, 32'd0);
            if (!pb) new_b(rnd_addr(), 4'd0, 32'd0);
            run_cycle(w);
            check("t2_seq", b_gnt, exp2[i]);
        end

        // Single read of a known word
        do_reset();
        set_word(4, 32'hDEADBEEF);
        new_a(32'h10, 4'd0, 32'd0);
        run_cycle(w);
        check("t1_addr", mem_addr, 32'h10);
        run_cycle(w);
        check("t1_rdata", a_rdata, 32'hDEADBEEF);

        // Partial write then read of the same word
        do_reset();
        set_word(8, 32'hAABBCCDD);
        new_a(32'h20, 4'b0011, 32'h11223344);
        new_b(32'h20, 4'd0, 32'd0);
        run_cycle(w);
        run_cycle(w);
        run_cycle(w);
        check("t3_rvalid", b_rvalid, 1);
        check("t3_rdata", b_rdata, 32'hAABB3344);

        // Uncontested A grants hand priority to B
        do_reset();
        for (int i = 0; i < 3; i++) begin
            new_a(rnd_addr(), 4'd0, 32'd0);
            run_cycle(w);
        end
        new_a(rnd_addr(), 4'd0, 32'd0);
        new_b(rnd_addr(), 4'd0, 32'd0);
        run_cycle(w);
        check("t4_bgnt", b_gnt, 1);

        // Reset while a response is outstanding
        do_reset();
        new_a(rnd_addr(), 4'd0, 32'd0);
        run_cycle(w);
        reset = 1'b1;
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk);
        #1;
        check("t5_rvalid", a_rvalid, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        new_a(rnd_addr(), 4'd0, 32'd0);
        new_b(rnd_addr(), 4'd0, 32'd0);
        run_cycle(w);
        check("t5_agnt", a_gnt, 1);

`ifdef DMEM_ARB_LOCK_EN
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_req = 1'b1; b_req = 1'b1;
            a_wmask = 4'd0; b_wmask = 4'd0;
            a_lock = (i < 3);
            #1;
            check("lock_a_gnt", a_gnt, i < 3);
            check("lock_b_gnt", b_gnt, i == 3);
        end
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0;
`endif

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (!pa && $urandom_range(0, 3) != 0)
                new_a(rnd_addr(), rnd_mask(), $urandom);
            if (!pb && $urandom_range(0, 3) != 0)
                new_b(rnd_addr(), rnd_mask(), $urandom);
            run_cycle(w);
        end
        pa = 1'b0; pb = 1'b0;
        run_cycle(w);
        run_cycle(w);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Weighted round-robin arbiter that shares one synchronous-read data-memory port (1-cycle read latency, byte write mask, read-before-write) between two requesters A and B, e.g. two harts or core plus loader/DMA. Sits between the requesters and the data memory. Muxes address, mask and write data onto the memory port and routes the registered read data back to the requester that was granted.

Parameters:
WEIGHT_A, 1, max consecutive grants to A while B is waiting (legal 1..15; 0 treated as 1)
WEIGHT_B, 1, max consecutive grants to B while A is waiting (legal 1..15; 0 treated as 1)

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
a_req  in  1  A access request; held stable until a_gnt
a_addr  in  32  A byte address; word select is bits [15:2]
a_wmask  in  4  A byte write mask; 0 = read
a_wdata  in  32  A write data
a_gnt  out  1  A granted this cycle (combinational)
a_rvalid  out  1  A response valid
a_rdata  out  32  A response data
b_req, b_addr, b_wmask, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
mem_addr  out  32  memory address
mem_wmask  out  4  memory byte write mask
mem_wdata  out  32  memory write data
mem_data  in  32  memory read data, valid 1 cycle after address

Behaviour:
- State: prio (0=A, 1=B), cnt (4 bits), owner_q, vld_q.
- Reset values: prio=A, cnt=0, vld_q=0.
- While reset is high: a_gnt=b_gnt=0, mem_wmask=0, a_rvalid=b_rvalid=0.
- Grant, combinational, at most one per cycle:
  - only one req high -> grant that requester
  - both high -> grant the prio holder
  - none high -> no grant
- mem_addr, mem_wmask, mem_wdata take the winner's signals.
- No grant -> mem_wmask=0 and mem_addr=a_addr (harmless read).
- State update on a grant to X while the other is also requesting:
  - if cnt+1 == WEIGHT_X: prio <= other, cnt <= 0
  - else: cnt <= cnt+1, prio <= X
- State update on a grant to X while the other is idle: prio <= other, cnt <= 0.
- No grant: prio and cnt hold.
- Response:
  - Every granted access, read or write, sets vld_q=1 and owner_q=X for the next cycle.
  - X_rvalid = vld_q && owner_q==X.
  - X_rdata = mem_data, exactly 1 cycle after the grant.
  - For writes, rdata is the pre-write word; requesters ignore it.
  - Non-owner rvalid is 0; non-owner rdata is don't-care (driven equal to mem_data).
- Back-to-back grants, including alternating A/B, give one response per cycle, with no bubbles and no reordering.
- Requester rules:
  - A request dropped before its gnt is simply never served.
  - A requester may re-request in the cycle its rvalid arrives.
- Reset mid-operation: an outstanding response is discarded (rvalid stays 0); state returns to reset values.
- cnt never exceeds 14; its width is fixed at 4 bits.

Optional Feature:
Macro: DMEM_ARB_LOCK_EN.
- With it defined:
  - Adds inputs a_lock and b_lock (1 bit each).
  - When X is granted with X_lock=1, a lock flag is set with owner X.
  - While the lock is set, only X may be granted; the other requester waits regardless of prio.
  - cnt is frozen while locked.
  - The lock clears on the first cycle where X_lock=0; arbitration then resumes that same cycle with prio = other.
  - Reset clears the lock.
- Without it: the lock ports do not exist and the arbiter is pure weighted round-robin.

Test Plan:
1. Only A reads addr 0x10, memory word = 0xDEADBEEF -> a_gnt=1 same cycle, mem_addr=0x10, mem_wmask=0; next cycle a_rvalid=1, a_rdata=0xDEADBEEF, b_rvalid=0.
2. WEIGHT_A=2, WEIGHT_B=1, both req held high for 6 cycles -> grant sequence A,A,B,A,A,B; rvalid follows each grant by 1 cycle with the matching owner.
3. Both request in the same cycle: A writes 0x20 with wmask=4'b0011 and wdata=0x11223344; B reads 0x20; memory word = 0xAABBCCDD -> A granted first, B granted next, b_rdata=0xAABB3344.
4. A alone requests for 3 cycles, then A and B request together -> B granted first in the contended cycle (prio flipped by the uncontested A grants).
5. A read granted, reset asserted the next cycle before rvalid -> a_rvalid stays 0; after reset release, with both requesting, A is granted first.
6. With DMEM_ARB_LOCK_EN defined: A holds a_lock=1 for 3 grants while b_req=1 -> b_gnt=0 throughout; a_lock drops -> b_gnt=1 in that cycle.
